// File: rtl/mem_bus_pkg.sv
// Shared types and helpers for the word-wide memory bus responder.
package mem_bus_pkg;

    typedef enum logic {IDLE, BUSY} state_e;

    localparam int BYTE_LANES = 4;

    function automatic logic [31:0] merge_bytes(input logic [31:0]           old_word,
                                                input logic [31:0]           new_word,
                                                input logic [BYTE_LANES-1:0] byteenable);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < BYTE_LANES; i++) begin
            if (byteenable[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

    // The upper limit is formed in 33 bits so a window ending at 4 GiB does not wrap.
    function automatic logic addr_in_range(input logic [31:0] address,
                                           input logic [31:0] base,
                                           input int unsigned depth);
        logic [32:0] limit;
        limit = {1'b0, base} + (33'(depth) << 2);
        return (address >= base) && ({1'b0, address} < limit);
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// Word array with one byte-enabled synchronous write port and one asynchronous read port.
// INIT_FILE names the image the implementation flow preloads; the RTL has no clear path.
module mem_word_array
    import mem_bus_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter string       INIT_FILE   = "",
    localparam int unsigned AW         = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [BYTE_LANES-1:0] byteenable,
    input  logic [31:0]           wdata,
    input  logic [AW-1:0]         raddr,
    output logic [31:0]           rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];

    // NOTE: the storage array is deliberately not reset; clearing it would need a
    // multi-cycle sweep and would also destroy contents that must survive a reset.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= merge_bytes(mem_q[waddr], wdata, byteenable);
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-mapped bus responder: wait-state FSM, range/alignment checks and output
// muxing in front of a byte-enabled word array.
module mem_bus_responder
    import mem_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter string       INIT_FILE   = ""
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           address,
    input  logic                  read,
    input  logic                  write,
    input  logic [BYTE_LANES-1:0] byteenable,
    input  logic [31:0]           writedata,
    output logic                  waitrequest,
    output logic [31:0]           readdata,
    output logic                  err
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_LOAD = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          req;
    logic          complete;
    logic          bad;
    logic          we;
    logic [AW-1:0] word_idx;
    logic [31:0]   rd_word;

    assign req = read | write;

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output of this block is given a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        waitrequest = 1'b0;
        complete    = 1'b0;
        if (reset) begin
            waitrequest = req;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        if (WAIT_CYCLES == 0) begin
                            complete = 1'b1;
                        end else begin
                            waitrequest = 1'b1;
                            state_d     = BUSY;
                            cnt_d       = CNT_LOAD;
                        end
                    end
                end
                BUSY: begin
                    if (!req) begin
                        // Initiator walked away: drop the transfer silently.
                        state_d = IDLE;
                    end else if (cnt_q != 4'd0) begin
                        waitrequest = 1'b1;
                        cnt_d       = cnt_q - 4'd1;
                    end else begin
                        complete = 1'b1;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bad = !addr_in_range(address, BASE_ADDR, DEPTH_WORDS)
                 || (address[1:0] != 2'b00)
                 || (read && write);

    assign word_idx = AW'((address - BASE_ADDR) >> 2);
    assign we       = complete && write && !bad;
    assign err      = complete && bad;
    assign readdata = (complete && read && !bad) ? rd_word : 32'h0;

    mem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .INIT_FILE   (INIT_FILE)
    ) u_array (
        .clk        (clk),
        .we         (we),
        .waddr      (word_idx),
        .byteenable (byteenable),
        .wdata      (writedata),
        .raddr      (word_idx),
        .rdata      (rd_word)
    );

endmodule
